// File: rtl/ccc_seq_pkg.sv
// Shared types and sizing helpers for the fabric clock sequencer.
package ccc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILTER  = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RUN     = 2'b11
  } state_e;

  localparam int unsigned LOSS_W = 8;

  // Bits needed to hold 0..max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned filt_w(input int unsigned lock_filt);
    return cnt_w(lock_filt - 1);
  endfunction

  function automatic int unsigned rel_w(input int unsigned num_ch, input int unsigned stagger);
    return cnt_w((num_ch - 1) * stagger);
  endfunction

endpackage

// File: rtl/ccc_clk_en_div.sv
// One channel of the enable divider: shadow divisor, active divisor, counter and registered strobe.
module ccc_clk_en_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             ch_run,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             en
);

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] next_div;
  logic             wrap;

  // A programmed divisor of 0 behaves as 1.
  assign div_eff  = (active == '0) ? DIV_W'(1) : active;
  assign wrap     = (cnt == (div_eff - DIV_W'(1)));
  // A load coinciding with the wrap governs the very next period.
  assign next_div = load ? val : shadow;

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      en     <= 1'b0;
    end else begin
      if (load) begin
        shadow <= val;
      end
      if (!ch_run) begin
        cnt    <= '0;
        en     <= 1'b0;
        active <= next_div;
      end else if (wrap) begin
        cnt    <= '0;
        en     <= 1'b1;
        active <= next_div;
      end else begin
        cnt    <= cnt + DIV_W'(1);
        en     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ccc_clk_seq.sv
// Fabric clock sequencer: lock qualification, staggered channel reset release, per-channel enables.
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN.
module ccc_clk_seq
  import ccc_seq_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 3,
  parameter  int unsigned DIV_W       = 8,
  parameter  int unsigned LOCK_FILT   = 16,
  parameter  int unsigned RST_STAGGER = 4,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              FAB_CLK,
  input  logic              RESET_N,
  input  logic              LOCK_IN,
  input  logic              DIV_LOAD,
  input  logic [CH_W-1:0]   DIV_CH,
  input  logic [DIV_W-1:0]  DIV_VAL,
  output logic [NUM_CH-1:0] CLK_EN,
  output logic [NUM_CH-1:0] CH_RST_N,
  output logic              LOCKED,
  output logic [1:0]        STATE,
  output logic [LOSS_W-1:0] LOSS_CNT
);

  localparam int unsigned FILT_W = filt_w(LOCK_FILT);
  localparam int unsigned REL_W  = rel_w(NUM_CH, RST_STAGGER);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'((NUM_CH - 1) * RST_STAGGER);

  logic              lock_m;
  logic              lock_s;
  state_e            state;
  state_e            state_nxt;
  logic [FILT_W-1:0] filt_cnt;
  logic [FILT_W-1:0] filt_nxt;
  logic [REL_W-1:0]  rel_cnt;
  logic [REL_W-1:0]  rel_nxt;
  logic [NUM_CH-1:0] ch_rst_n_q;
  logic [NUM_CH-1:0] ch_rst_n_nxt;
  logic              locked_q;
  logic              locked_nxt;
  logic [NUM_CH-1:0] ch_run;

  // Two-flop synchroniser for the asynchronous CCC lock.
  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= LOCK_IN;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      filt_cnt   <= '0;
      rel_cnt    <= '0;
      ch_rst_n_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      filt_cnt   <= filt_nxt;
      rel_cnt    <= rel_nxt;
      ch_rst_n_q <= ch_rst_n_nxt;
      locked_q   <= locked_nxt;
    end
  end

  // Next-state and next-output logic; losing lock anywhere drops straight to IDLE.
  always_comb begin
    state_nxt    = state;
    filt_nxt     = filt_cnt;
    rel_nxt      = rel_cnt;
    ch_rst_n_nxt = ch_rst_n_q;
    locked_nxt   = 1'b0;
    if (!lock_s) begin
      state_nxt    = ST_IDLE;
      filt_nxt     = '0;
      rel_nxt      = '0;
      ch_rst_n_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_FILTER;
          filt_nxt  = '0;
        end
        ST_FILTER: begin
          if (filt_cnt == FILT_LAST) begin
            state_nxt = ST_RELEASE;
            rel_nxt   = '0;
          end else begin
            filt_nxt = filt_cnt + FILT_W'(1);
          end
        end
        ST_RELEASE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (rel_cnt == REL_W'(i * RST_STAGGER)) begin
              ch_rst_n_nxt[i] = 1'b1;
            end
          end
          if (rel_cnt == REL_LAST) begin
            state_nxt  = ST_RUN;
            locked_nxt = 1'b1;
          end else begin
            rel_nxt = rel_cnt + REL_W'(1);
          end
        end
        ST_RUN: begin
          locked_nxt = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // A channel counts only while out of reset now and after this edge, so CLK_EN drops with CH_RST_N.
  assign ch_run = ch_rst_n_q & ch_rst_n_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ccc_clk_en_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .FAB_CLK (FAB_CLK),
      .RESET_N (RESET_N),
      .ch_run  (ch_run[g]),
      .load    (DIV_LOAD && (DIV_CH == CH_W'(g))),
      .val     (DIV_VAL),
      .en      (CLK_EN[g])
    );
  end

  assign CH_RST_N = ch_rst_n_q;
  assign LOCKED   = locked_q;
  assign STATE    = state;

`ifdef LOCK_LOSS_CNT_EN
  logic              loss_inc;
  logic [LOSS_W-1:0] loss_cnt;

  // Only losses after channels started releasing are counted; filter dropouts are not.
  assign loss_inc = !lock_s && ((state == ST_RELEASE) || (state == ST_RUN));

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      loss_cnt <= '0;
    end else if (loss_inc && (loss_cnt != {LOSS_W{1'b1}})) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign LOSS_CNT = loss_cnt;
`else
  assign LOSS_CNT = '0;
`endif

endmodule

// File: tb/tb_ccc_clk_seq.sv
// Self-checking bench for ccc_clk_seq with default parameters.
module tb_ccc_clk_seq;

  localparam int NCH    = 3;
  localparam int LF     = 16;
  localparam int ST     = 4;
  localparam int T_FILT = 3;
  localparam int T_REL  = T_FILT + LF;
  localparam int T_CH0  = T_REL + 1;
  localparam int T_RUN  = T_CH0 + (NCH - 1) * ST;
`ifdef LOCK_LOSS_CNT_EN
  localparam int NLOSS = 300;
`else
  localparam int NLOSS = 4;
`endif

  logic       FAB_CLK = 1'b0;
  logic       RESET_N;
  logic       LOCK_IN;
  logic       DIV_LOAD;
  logic [1:0] DIV_CH;
  logic [7:0] DIV_VAL;
  logic [2:0] CLK_EN;
  logic [2:0] CH_RST_N;
  logic       LOCKED;
  logic [1:0] STATE;
  logic [7:0] LOSS_CNT;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  ccc_clk_seq dut (
    .FAB_CLK  (FAB_CLK),
    .RESET_N  (RESET_N),
    .LOCK_IN  (LOCK_IN),
    .DIV_LOAD (DIV_LOAD),
    .DIV_CH   (DIV_CH),
    .DIV_VAL  (DIV_VAL),
    .CLK_EN   (CLK_EN),
    .CH_RST_N (CH_RST_N),
    .LOCKED   (LOCKED),
    .STATE    (STATE),
    .LOSS_CNT (LOSS_CNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [1:0] exp_state(input int r);
    if (r < T_FILT) return 2'b00;
    if (r < T_REL)  return 2'b01;
    if (r < T_RUN)  return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [2:0] exp_rst(input int r);
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) if (r >= T_CH0 + i * ST) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_loss(input int n);
`ifdef LOCK_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic step();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N  = 1'b0;
    LOCK_IN  = 1'b0;
    DIV_LOAD = 1'b0;
    DIV_CH   = 2'd0;
    DIV_VAL  = 8'd0;
    repeat (2) @(posedge FAB_CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic load_div(input logic [1:0] ch, input logic [7:0] v);
    DIV_LOAD = 1'b1;
    DIV_CH   = ch;
    DIV_VAL  = v;
    step();
    DIV_LOAD = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; LOCK_IN = 1'b0; DIV_LOAD = 1'b0; DIV_CH = 2'd0; DIV_VAL = 8'd0;
    #3;
    checks++; if (STATE !== 2'b00)    begin errors++; $display("FAIL reset_state got %b exp 00", STATE); end
    checks++; if (CH_RST_N !== 3'b000) begin errors++; $display("FAIL reset_ch_rst_n got %b exp 000", CH_RST_N); end
    checks++; if (CLK_EN !== 3'b000)   begin errors++; $display("FAIL reset_clk_en got %b exp 000", CLK_EN); end
    checks++; if (LOCKED !== 1'b0)     begin errors++; $display("FAIL reset_locked got %b exp 0", LOCKED); end
    checks++; if (LOSS_CNT !== 8'd0)   begin errors++; $display("FAIL reset_loss_cnt got %0d exp 0", LOSS_CNT); end
  endtask

  task automatic test_lock_sequence();
    logic [2:0] e;
    do_reset();
    LOCK_IN = 1'b1;
    for (int r = 1; r <= 32; r++) begin
      step();
      for (int i = 0; i < NCH; i++) e[i] = (r >= T_CH0 + i * ST + 1);
      checks++; if (STATE !== exp_state(r)) begin errors++; $display("FAIL seq_state r=%0d got %b exp %b", r, STATE, exp_state(r)); end
      checks++; if (CH_RST_N !== exp_rst(r)) begin errors++; $display("FAIL seq_ch_rst_n r=%0d got %b exp %b", r, CH_RST_N, exp_rst(r)); end
      checks++; if (LOCKED !== (r >= 28)) begin errors++; $display("FAIL seq_locked r=%0d got %b exp %b", r, LOCKED, (r >= 28)); end
      checks++; if (CLK_EN !== e) begin errors++; $display("FAIL seq_clk_en r=%0d got %b exp %b", r, CLK_EN, e); end
    end
  endtask

  task automatic test_filter_glitch();
    do_reset();
    LOCK_IN = 1'b1;
    repeat (13) step();
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL glitch_in_filter got %b exp 01", STATE); end
    LOCK_IN = 1'b0;
    repeat (3) step();
    LOCK_IN = 1'b1;
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL glitch_idle got %b exp 00", STATE); end
    for (int r = 1; r <= 32; r++) begin
      step();
      checks++; if (STATE !== exp_state(r)) begin errors++; $display("FAIL glitch_state r=%0d got %b exp %b", r, STATE, exp_state(r)); end
      checks++; if (CH_RST_N !== exp_rst(r)) begin errors++; $display("FAIL glitch_ch_rst_n r=%0d got %b exp %b", r, CH_RST_N, exp_rst(r)); end
      checks++; if (LOCKED !== (r >= T_RUN)) begin errors++; $display("FAIL glitch_locked r=%0d got %b exp %b", r, LOCKED, (r >= T_RUN)); end
    end
    checks++; if (LOSS_CNT !== 8'd0) begin errors++; $display("FAIL glitch_loss_cnt got %0d exp 0", LOSS_CNT); end
  endtask

  task automatic test_divider_update();
    logic [2:0] e;
    int t;
    do_reset();
    load_div(2'd0, 8'd4);
    load_div(2'd1, 8'd3);
    load_div(2'd2, 8'd2);
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 24; k <= 75; k += 4) q0.push_back(k);
    t = 27;
    while (t <= 75) begin q1.push_back(t); t += (t < 36) ? 3 : 5; end
    for (int k = 30; k <= 75; k += 2) q2.push_back(k);
    LOCK_IN = 1'b1;
    DIV_CH  = 2'd1;
    DIV_VAL = 8'd5;
    for (int k = 1; k <= 75; k++) begin
      DIV_LOAD = (k == 35);
      step();
      e[0] = (q0.size() > 0 && q0[0] == k); if (e[0]) void'(q0.pop_front());
      e[1] = (q1.size() > 0 && q1[0] == k); if (e[1]) void'(q1.pop_front());
      e[2] = (q2.size() > 0 && q2[0] == k); if (e[2]) void'(q2.pop_front());
      checks++; if (CLK_EN !== e) begin errors++; $display("FAIL div_strobe k=%0d got %b exp %b", k, CLK_EN, e); end
    end
    DIV_LOAD = 1'b0;
  endtask

  task automatic test_div_zero_one();
    logic [2:0] e;
    do_reset();
    load_div(2'd0, 8'd0);
    load_div(2'd1, 8'd1);
    load_div(2'd2, 8'd3);
    LOCK_IN = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      DIV_LOAD = (k == 35) || (k == 40);
      DIV_CH   = (k == 40) ? 2'd3 : 2'd0;
      DIV_VAL  = (k == 40) ? 8'd7 : 8'd1;
      step();
      e[0] = (k >= 21);
      e[1] = (k >= 25);
      e[2] = (k >= 31) && ((k - 28) % 3 == 0);
      checks++; if (CLK_EN !== e) begin errors++; $display("FAIL div01_strobe k=%0d got %b exp %b", k, CLK_EN, e); end
    end
    DIV_LOAD = 1'b0;
  endtask

  task automatic test_lock_loss();
    logic got;
    do_reset();
    LOCK_IN = 1'b1;
    repeat (40) step();
    LOCK_IN = 1'b0;
    repeat (2) step();
    checks++; if (LOCKED !== 1'b1 || STATE !== 2'b11) begin errors++; $display("FAIL loss_still_run locked=%b state=%b exp 1/11", LOCKED, STATE); end
    step();
    checks++; if (STATE !== 2'b00)    begin errors++; $display("FAIL loss_state got %b exp 00", STATE); end
    checks++; if (CH_RST_N !== 3'b000) begin errors++; $display("FAIL loss_ch_rst_n got %b exp 000", CH_RST_N); end
    checks++; if (CLK_EN !== 3'b000)   begin errors++; $display("FAIL loss_clk_en got %b exp 000", CLK_EN); end
    checks++; if (LOCKED !== 1'b0)     begin errors++; $display("FAIL loss_locked got %b exp 0", LOCKED); end
    checks++; if (LOSS_CNT !== exp_loss(1)) begin errors++; $display("FAIL loss_cnt_1 got %0d exp %0d", LOSS_CNT, exp_loss(1)); end
    for (int n = 2; n <= NLOSS; n++) begin
      LOCK_IN = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin step(); got = (STATE == 2'b10); end
      checks++; if (!got) begin errors++; $display("FAIL loss_reach_release n=%0d state=%b exp 10", n, STATE); end
      LOCK_IN = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin step(); got = (STATE == 2'b00); end
      checks++; if (!got) begin errors++; $display("FAIL loss_reach_idle n=%0d state=%b exp 00", n, STATE); end
      checks++; if (LOSS_CNT !== exp_loss(n)) begin errors++; $display("FAIL loss_cnt n=%0d got %0d exp %0d", n, LOSS_CNT, exp_loss(n)); end
    end
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    LOCK_IN = 1'b1;
    repeat (22) step();
    checks++; if (STATE !== 2'b10 || CH_RST_N !== 3'b001) begin errors++; $display("FAIL mid_release state=%b ch_rst_n=%b exp 10/001", STATE, CH_RST_N); end
    RESET_N = 1'b0;
    #1;
    checks++; if (STATE !== 2'b00)    begin errors++; $display("FAIL arst_state got %b exp 00", STATE); end
    checks++; if (CH_RST_N !== 3'b000) begin errors++; $display("FAIL arst_ch_rst_n got %b exp 000", CH_RST_N); end
    checks++; if (CLK_EN !== 3'b000)   begin errors++; $display("FAIL arst_clk_en got %b exp 000", CLK_EN); end
    checks++; if (LOCKED !== 1'b0)     begin errors++; $display("FAIL arst_locked got %b exp 0", LOCKED); end
    repeat (2) @(posedge FAB_CLK);
    #1;
    RESET_N = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      step();
      checks++; if (STATE !== exp_state(r)) begin errors++; $display("FAIL restart_state r=%0d got %b exp %b", r, STATE, exp_state(r)); end
      checks++; if (CH_RST_N !== exp_rst(r)) begin errors++; $display("FAIL restart_ch_rst_n r=%0d got %b exp %b", r, CH_RST_N, exp_rst(r)); end
      checks++; if (LOCKED !== (r >= T_RUN)) begin errors++; $display("FAIL restart_locked r=%0d got %b exp %b", r, LOCKED, (r >= T_RUN)); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_filter_glitch();
    test_divider_update();
    test_div_zero_one();
    test_lock_loss();
    test_reset_mid_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
